inst_loader: RTL and testbench

- Boot-time program loader directly upstream of the instruction memory.
- Receives a framed byte stream (from a UART receiver or test host) and assembles little-endian 32-bit instruction words.
- Writes the words into the instruction memory through its write port.
- Holds the processor core in reset until the whole image has loaded and the checksum passes.

---
 rtl/inst_loader.sv | 172 +++++++++++++++++
 tb/tb_inst_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: boot-time program loader in front of the instruction memory.
// It parses a framed byte stream: 0xA5, LEN_LO, LEN_HI, then 4*N data bytes
// (little-endian words), then an XOR checksum of the data bytes. The core is
// held in reset until a complete image has been written and the checksum
// has matched.
//
// Optional build macro: LOADER_TIMEOUT_EN. When it is defined, an inter-byte
// idle counter forces the error state after TIMEOUT_CYC cycles without a
// byte while a frame is in progress. When it is not defined, the loader waits
// indefinitely in every state.
//
// Handshake: a byte transfers on a rising Clk edge where Rx_valid && Rx_ready.
// Rx_ready depends only on registered state (it is low only in RUN), so the
// sender may hold Rx_valid/Rx_data for as long as it likes, and no
// combinational path runs from Rx_valid to Rx_ready.
module inst_loader #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Rx_valid,
    input  logic [7:0]        Rx_data,
    output logic              Rx_ready,
    output logic              Imem_wr_en,
    output logic [ADDR_W-1:0] Imem_wr_addr,
    output logic [31:0]       Imem_wr_data,
    output logic              Core_rst_n,
    output logic              Load_done,
    output logic              Err,
    output logic [2:0]        o_dbg_state
);

    // The word index must be able to reach DEPTH_WORDS itself.
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_RUN  = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_len;
    logic [IDX_W-1:0]  r_idx;
    logic [1:0]        r_lane;
    logic [23:0]       r_word;
    logic [7:0]        r_csum;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;

    logic              w_acc;
    logic [15:0]       w_len_new;
    logic              w_len_oversize;
    logic [IDX_W-1:0]  w_idx_inc;
    logic              w_last_word;
    logic              w_timeout;

    assign Rx_ready       = (r_state != S_RUN);
    assign w_acc          = Rx_valid && Rx_ready;
    assign w_len_new      = {Rx_data, r_len[7:0]};
    assign w_len_oversize = ({16'd0, w_len_new} > DEPTH_WORDS);
    assign w_idx_inc      = r_idx + IDX_W'(1);
    assign w_last_word    = (32'(w_idx_inc) == 32'(r_len));

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_idle_cnt;
    logic             w_cnt_active;

    assign w_cnt_active = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                          (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_timeout    = w_cnt_active && !w_acc &&
                          (r_idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Idle counter: cleared by every accepted byte and outside a frame.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_idle_cnt <= '0;
        end else if (!w_cnt_active || w_acc) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;

    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; RUN and ERR are terminal until reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_acc && Rx_data == 8'hA5) w_state_nxt = S_LEN0;
            S_LEN0: if (w_acc) w_state_nxt = S_LEN1;
            S_LEN1: begin
                if (w_acc) begin
                    if (w_len_oversize)        w_state_nxt = S_ERR;
                    else if (w_len_new == '0)  w_state_nxt = S_CSUM;
                    else                       w_state_nxt = S_DATA;
                end
            end
            S_DATA: if (w_acc && r_lane == 2'd3 && w_last_word) w_state_nxt = S_CSUM;
            S_CSUM: if (w_acc) w_state_nxt = (Rx_data == r_csum) ? S_RUN : S_ERR;
            default: w_state_nxt = r_state;
        endcase
        if (w_timeout) w_state_nxt = S_ERR;
    end

    // Datapath: length capture, word assembly, checksum and write strobe.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_len     <= '0;
            r_idx     <= '0;
            r_lane    <= '0;
            r_word    <= '0;
            r_csum    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_acc) begin
                case (r_state)
                    S_LEN0: r_len[7:0]  <= Rx_data;
                    S_LEN1: r_len[15:8] <= Rx_data;
                    S_DATA: begin
                        r_csum <= r_csum ^ Rx_data;
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'd3) begin
                            r_wr_data <= {Rx_data, r_word};
                            r_wr_addr <= ADDR_W'(r_idx) << 2;
                            r_wr_en   <= 1'b1;
                            r_idx     <= w_idx_inc;
                        end else begin
                            r_word <= {Rx_data, r_word[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Imem_wr_en   = r_wr_en;
    assign Imem_wr_addr = r_wr_addr;
    assign Imem_wr_data = r_wr_data;
    assign Core_rst_n   = (r_state == S_RUN);
    assign Load_done    = (r_state == S_RUN);
    assign Err          = (r_state == S_ERR);
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: frames are built from random or literal word lists,
// the expected memory writes and final outcome are derived from the frame
// contents, and a negedge monitor checks every write strobe against them.
module tb_inst_loader;

  localparam int DEPTH = 256;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Rx_valid = 1'b0;
  logic [7:0]  Rx_data = 8'h00;
  logic        Rx_ready;
  logic        Imem_wr_en;
  logic [31:0] Imem_wr_addr;
  logic [31:0] Imem_wr_data;
  logic        Core_rst_n;
  logic        Load_done;
  logic        Err;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model_log[$];
  logic [31:0] lit_words[$];
  logic [7:0]  last_csum;
  logic [63:0] mon_exp;

  // clock / reset
  always #5 Clk = ~Clk;

  inst_loader #(
    .ADDR_W(32),
    .DEPTH_WORDS(DEPTH),
    .TIMEOUT_CYC(100000)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Rx_valid(Rx_valid),
    .Rx_data(Rx_data),
    .Rx_ready(Rx_ready),
    .Imem_wr_en(Imem_wr_en),
    .Imem_wr_addr(Imem_wr_addr),
    .Imem_wr_data(Imem_wr_data),
    .Core_rst_n(Core_rst_n),
    .Load_done(Load_done),
    .Err(Err),
    .o_dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge Clk) begin
    if (Rst_n && Imem_wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                 Imem_wr_addr, Imem_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("imem_write", {Imem_wr_addr, Imem_wr_data}, mon_exp);
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    Rx_valid = 1'b1;
    Rx_data  = b;
    @(negedge Clk);
    Rx_valid = 1'b0;
    Rx_data  = 8'($urandom);
  endtask

  task automatic maybe_gap(input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
  endtask

  task automatic do_reset();
    Rx_valid = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 64'(Rx_ready), 64'd1);
    chk({tag, "_wr_en"}, 64'(Imem_wr_en), 64'd0);
    chk({tag, "_wr_addr"}, 64'(Imem_wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(Imem_wr_data), 64'd0);
    chk({tag, "_core_rst_n"}, 64'(Core_rst_n), 64'd0);
    chk({tag, "_load_done"}, 64'(Load_done), 64'd0);
    chk({tag, "_err"}, 64'(Err), 64'd0);
  endtask

  // One complete frame. The reference outcome: a length above DEPTH is an
  // error with no writes; otherwise word i lands at byte address 4*i, and the
  // load succeeds exactly when the checksum equals the XOR of the data bytes.
  task automatic run_frame(input int n, input bit bad, input int n_garbage,
                           input bit gaps, input bit use_lit);
    logic [7:0]  csum;
    logic [7:0]  b;
    logic [7:0]  flip;
    logic [15:0] len;
    logic [31:0] w;
    bit          exp_ok;
    do_reset();
    model_log.delete();
    csum = 8'h00;
    len  = 16'(n);
    for (int g = 0; g < n_garbage; g++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h3C;
      send_byte(b);
      maybe_gap(gaps);
    end
    send_byte(8'hA5);
    maybe_gap(gaps);
    send_byte(len[7:0]);
    maybe_gap(gaps);
    send_byte(len[15:8]);
    if (n > DEPTH) begin
      chk("oversize_err", 64'(Err), 64'd1);
      for (int j = 0; j < 4; j++) send_byte(8'($urandom));
      chk("oversize_rx_ready", 64'(Rx_ready), 64'd1);
      chk("oversize_core_rst_n", 64'(Core_rst_n), 64'd0);
      chk("oversize_load_done", 64'(Load_done), 64'd0);
      chk("oversize_no_writes", 64'(exp_q.size()), 64'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = use_lit ? lit_words[i] : $urandom;
      exp_q.push_back({32'(i * 4), w});
      model_log.push_back({32'(i * 4), w});
      for (int k = 0; k < 4; k++) begin
        maybe_gap(gaps);
        b = w[8*k +: 8];
        csum = csum ^ b;
        send_byte(b);
      end
    end
    last_csum = csum;
    flip = use_lit ? 8'h01 : 8'($urandom_range(1, 255));
    exp_ok = !bad;
    maybe_gap(gaps);
    send_byte(bad ? (csum ^ flip) : csum);
    // one cycle after the checksum byte is accepted
    chk("done_after_csum", 64'(Load_done), 64'(exp_ok));
    chk("core_rst_after_csum", 64'(Core_rst_n), 64'(exp_ok));
    chk("err_after_csum", 64'(Err), 64'(!exp_ok));
    chk("rx_ready_after_csum", 64'(Rx_ready), 64'(!exp_ok));
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    if (bad) begin
      for (int j = 0; j < 3; j++) send_byte(8'($urandom));
      chk("err_drain_ready", 64'(Rx_ready), 64'd1);
      chk("err_sticky", 64'(Err), 64'd1);
      chk("err_core_held", 64'(Core_rst_n), 64'd0);
    end else begin
      repeat (3) @(negedge Clk);
      chk("run_hold_done", 64'(Load_done), 64'd1);
    end
  endtask

  // watchdog
  initial begin
    #5000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    int n;
    int r;
    lit_words.push_back(32'h00500513);
    lit_words.push_back(32'h00A00593);

    // reset values, during and after reset
    repeat (2) @(negedge Clk);
    chk_reset_outputs("in_reset");
    Rst_n = 1'b1;
    @(negedge Clk);
    chk_reset_outputs("after_reset");

    // two-word literal load, then pin the model against hand-computed values
    run_frame(2, 1'b0, 0, 1'b0, 1'b1);
    chk("model_csum_pin", 64'(last_csum), 64'h70);
    chk("model_wr0_pin", model_log[0], {32'h0, 32'h00500513});
    chk("model_wr1_pin", model_log[1], {32'h4, 32'h00A00593});

    // bad checksum on the same frame
    run_frame(2, 1'b1, 0, 1'b0, 1'b1);

    // oversize length 257, and zero-length frame
    run_frame(257, 1'b0, 0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 0, 1'b0, 1'b0);

    // leading garbage 00 FF 5A then the literal frame
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    chk("garbage_stays_idle", 64'(Rx_ready), 64'd1);
    run_frame(2, 1'b0, 3, 1'b0, 1'b1);

    // abort after 6 data bytes, asynchronous reset mid-cycle
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    exp_q.push_back({32'h0, 32'h00500513});
    send_byte(8'h13);
    send_byte(8'h05);
    send_byte(8'h50);
    send_byte(8'h00);
    send_byte(8'h93);
    send_byte(8'h05);
    chk("abort_first_write_seen", 64'(exp_q.size()), 64'd0);
    #2;
    Rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_abort");
    @(negedge Clk);
    Rst_n = 1'b1;
    run_frame(2, 1'b0, 0, 1'b0, 1'b1);

    // full-depth image, last write at (DEPTH-1)*4
    run_frame(DEPTH, 1'b0, 0, 1'b0, 1'b0);
    chk("model_last_addr_pin", 64'(model_log[DEPTH-1][63:32]), 64'h3FC);

    // randomized frames
    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      n = 0;
      else if (r == 1) n = DEPTH;
      else if (r == 2) n = DEPTH + 1 + $urandom_range(0, 300);
      else             n = $urandom_range(1, 6);
      run_frame(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'b1, 1'b0);
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
